// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t  : responder FSM encoding (IDLE / WAIT / RESP)
//   DW_BYTES : byte lanes per doubleword
//   OFFSET_W : byte-offset bits inside a doubleword
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DW_BYTES = 8;
  localparam int OFFSET_W = 3;

endpackage

// File: rtl/dmem_responder_array.sv
// Doubleword RAM with byte-lane write enables.
// Synchronous write, combinational read; contents are not reset.
//   i_clk   : clock, rising edge
//   i_we    : write strobe for this cycle
//   i_idx   : doubleword index
//   i_be    : byte-lane enables (bit b -> bits 8b+7:8b)
//   i_wdata : write data, little-endian lanes
//   o_rdata : current contents of entry i_idx
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [DW_BYTES-1:0]     i_be,
  input  logic [DW_BYTES*8-1:0]   i_wdata,
  output logic [DW_BYTES*8-1:0]   o_rdata
);

  logic [DW_BYTES-1:0][7:0] r_mem [2**IDX_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW_BYTES; b++) begin
        if (i_be[b]) r_mem[i_idx][b] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store interface.
// Accepts one request at a time, waits LATENCY cycles, then performs the
// access and presents a response held until resp_ready.
//   clk, reset      : clock / async active-high reset
//   req_*           : request channel (valid/ready, we, addr, wdata, be)
//   resp_*          : response channel (valid/ready, rdata, err, is_write)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DW_BYTES-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_is_write
);

  localparam int IDX_W = ADDR_W - OFFSET_W;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_req_ready, r_resp_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DW_BYTES-1:0] r_be;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err, r_resp_is_write;

  logic                w_accept, w_access, w_misal, w_mem_we;
  logic [DATA_W-1:0]   w_rd;

  assign w_accept = req_valid && r_req_ready;
  // Access edge: last WAIT cycle; everything uses the captured request.
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_misal  = |r_addr[OFFSET_W-1:0];
  assign w_mem_we = w_access && r_we && !w_misal;

  dmem_array #(.IDX_W(IDX_W)) u_array (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_idx   (r_addr[ADDR_W-1:OFFSET_W]),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .o_rdata (w_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so no input has a
  // combinational path to req_ready or resp_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= 4'(LATENCY - 1);
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Loaded only at the access edge, so they hold through backpressure.
  // w_rd is sampled before the (possible) write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_rdata    <= '0;
      r_resp_err      <= 1'b0;
      r_resp_is_write <= 1'b0;
    end else if (w_access) begin
      r_resp_rdata    <= (r_we || w_misal) ? '0 : w_rd;
      r_resp_err      <= w_misal;
      r_resp_is_write <= r_we;
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign resp_is_write = r_resp_is_write;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_be;
  logic              resp_valid, resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err, resp_is_write;

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(64), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_is_write (resp_is_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request, verify latency/ready during WAIT, compare the
  // response against the scoreboard, optionally hold resp_ready low.
  task automatic run_txn(input logic we, input logic [11:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be,
                         input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr[ADDR_W-1:0];
    req_wdata  = wdata;
    req_be     = be;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    // scramble inputs: the DUT must use its captured copy
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr[ADDR_W-1:0];
    req_wdata = {$urandom, $urandom};
    req_be    = ~be;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (!resp_valid) chk("req_ready_wait", 64'(req_ready), 64'(0));
    end
    chk("latency", 64'(n), 64'(LATENCY + 1));
    e = sb.pop_front();
    if (!resp_valid) return;
    chk("rdata", resp_rdata, e.rdata);
    chk("err", 64'(resp_err), 64'(e.err));
    chk("is_write", 64'(resp_is_write), 64'(e.wr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'(1));
      chk("bp_ready", 64'(req_ready), 64'(0));
      chk("bp_rdata", resp_rdata, e.rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", 64'(resp_valid), 64'(0));
    chk("post_ready", 64'(req_ready), 64'(1));
  endtask

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    vecs[0]  = '{1'b1, 12'h010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 64'h0, 8'hFF, 64'h11223344AAAAAAAA, 1'b0};
    vecs[4]  = '{1'b1, 12'h013, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    vecs[5]  = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[6]  = '{1'b1, 12'h408, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0};
    vecs[7]  = '{1'b0, 12'h008, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 12'h020, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vecs[9]  = '{1'b1, 12'h020, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
    vecs[10] = '{1'b0, 12'h020, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vecs[11] = '{1'b0, 12'h021, 64'h0, 8'h00, 64'h0, 1'b1};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_err", 64'(resp_err), 64'(0));
    chk("rst_is_write", 64'(resp_is_write), 64'(0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].rdata, vecs[i].err, vecs[i].we});
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0);
    end

    // backpressure: load held for 5 cycles
    sb.push_back('{64'h11223344AAAAAAAA, 1'b0, 1'b0});
    run_txn(1'b0, 12'h010, 64'h0, 8'h00, 5);

    // reset during WAIT of a store to 0x020
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020;
    req_wdata = 64'h5555555555555555; req_be = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_rdata", resp_rdata, 64'h0);
    chk("mid_rst_err", 64'(resp_err), 64'(0));
    chk("mid_rst_is_write", 64'(resp_is_write), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("no_resp_after_rst", 64'(seen), 64'(0));
    sb.push_back('{64'h0123456789ABCDEF, 1'b0, 1'b0});
    run_txn(1'b0, 12'h020, 64'h0, 8'h00, 0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
